// File: rtl/sobel_window_core.sv
// -----------------------------------------------------------------------------
// sobel_window_core
//   Consumer end of the two-line shift buffer in the Sobel path. Builds a 3x3
//   window from the current-row pixel and the two delayed-row taps, then
//   computes |Gx|+|Gy| and a threshold decision in a 3-stage pipeline.
//   Sync/enable signals are delayed by the same 3 flops. Output pixel (r,c)
//   carries the edge of centre (r-1,c-1); rows 0,1 and cols 0,1 output 0.
//
// Ports
//   clk, rst_n        pixel clock, asynchronous active-low reset
//   de_in/hs_in/vs_in active video, hsync, vsync (rising edge = new frame)
//   pix_in,tap1,tap2  column c of rows r, r-1, r-2 (aligned when de_in=1)
//   thresh            edge threshold, compared against mag each cycle
//   de_out/hs_out/vs_out  inputs delayed by 3 clk
//   mag_out           |Gx|+|Gy| saturated to 255
//   edge_out          8'hFF when mag > thresh, else 8'h00
// -----------------------------------------------------------------------------
module sobel_window_core #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 12,
  parameter int MAG_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              de_in,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic [DATA_W-1:0] pix_in,
  input  logic [DATA_W-1:0] tap1,
  input  logic [DATA_W-1:0] tap2,
  input  logic [MAG_W-1:0]  thresh,
  output logic              de_out,
  output logic              hs_out,
  output logic              vs_out,
  output logic [7:0]        mag_out,
  output logic [7:0]        edge_out
);

  localparam int GW = DATA_W + 3;  // signed gradient width
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------------------------------------------------------- counters
  logic             de_prev_reg, vs_prev_reg, synced_reg;
  logic [CNT_W-1:0] col_cnt_reg, row_cnt_reg;
  logic             vs_rise, de_fall;
  logic [CNT_W-1:0] row_eff;
  logic             tag_now;

  assign vs_rise = vs_in & ~vs_prev_reg;
  assign de_fall = ~de_in & de_prev_reg;
  // A vs rise coinciding with a pixel tags that pixel as row 0.
  assign row_eff = vs_rise ? '0 : row_cnt_reg;
  // synced_reg keeps a frame that was cut by reset blanked until the next vs rise.
  assign tag_now = de_in && (synced_reg || vs_rise) &&
                   (row_eff >= CNT_W'(2)) && (col_cnt_reg >= CNT_W'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_prev_reg <= 1'b0;
      vs_prev_reg <= 1'b0;
      synced_reg  <= 1'b0;
      col_cnt_reg <= '0;
      row_cnt_reg <= '0;
    end else begin
      de_prev_reg <= de_in;
      vs_prev_reg <= vs_in;
      if (vs_rise) synced_reg <= 1'b1;

      if (de_fall)
        col_cnt_reg <= '0;
      else if (de_in && col_cnt_reg != CNT_MAX)
        col_cnt_reg <= col_cnt_reg + 1'b1;

      if (vs_rise)
        row_cnt_reg <= '0;
      else if (de_fall && row_cnt_reg != CNT_MAX)
        row_cnt_reg <= row_cnt_reg + 1'b1;
    end
  end

  // ------------------------------------------------------- stage 1: window
  // win_reg[k][j]: k = row (0 oldest = tap2), j = column (0 oldest).
  logic [DATA_W-1:0] win_reg [3][3];
  logic [DATA_W-1:0] row_new [3];
  logic              tag1_reg, de1_reg, hs1_reg, vs1_reg;

  assign row_new[0] = tap2;
  assign row_new[1] = tap1;
  assign row_new[2] = pix_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++)
        for (int j = 0; j < 3; j++)
          win_reg[k][j] <= '0;
      tag1_reg <= 1'b0;
      de1_reg  <= 1'b0;
      hs1_reg  <= 1'b0;
      vs1_reg  <= 1'b0;
    end else begin
      if (de_in) begin
        for (int k = 0; k < 3; k++) begin
          win_reg[k][0] <= win_reg[k][1];
          win_reg[k][1] <= win_reg[k][2];
          win_reg[k][2] <= row_new[k];
        end
      end
      tag1_reg <= tag_now;
      de1_reg  <= de_in;
      hs1_reg  <= hs_in;
      vs1_reg  <= vs_in;
    end
  end

  // ---------------------------------------------------- stage 2: gradients
  function automatic logic signed [GW-1:0] ext(input logic [DATA_W-1:0] p);
    return signed'({3'b000, p});
  endfunction

  logic signed [GW-1:0] gx_next, gy_next, gx_reg, gy_reg;
  logic                 tag2_reg, de2_reg, hs2_reg, vs2_reg;

  always_comb begin
    gx_next = (ext(win_reg[0][2]) + (ext(win_reg[1][2]) <<< 1) + ext(win_reg[2][2]))
            - (ext(win_reg[0][0]) + (ext(win_reg[1][0]) <<< 1) + ext(win_reg[2][0]));
    gy_next = (ext(win_reg[2][0]) + (ext(win_reg[2][1]) <<< 1) + ext(win_reg[2][2]))
            - (ext(win_reg[0][0]) + (ext(win_reg[0][1]) <<< 1) + ext(win_reg[0][2]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx_reg   <= '0;
      gy_reg   <= '0;
      tag2_reg <= 1'b0;
      de2_reg  <= 1'b0;
      hs2_reg  <= 1'b0;
      vs2_reg  <= 1'b0;
    end else begin
      gx_reg   <= gx_next;
      gy_reg   <= gy_next;
      tag2_reg <= tag1_reg;
      de2_reg  <= de1_reg;
      hs2_reg  <= hs1_reg;
      vs2_reg  <= vs1_reg;
    end
  end

  // ---------------------------------------------- stage 3: magnitude/edge
  logic [GW-1:0]    gx_abs, gy_abs;
  logic [MAG_W-1:0] mag_next;
  logic             valid3;

  always_comb begin
    gx_abs   = gx_reg[GW-1] ? GW'(-gx_reg) : GW'(gx_reg);
    gy_abs   = gy_reg[GW-1] ? GW'(-gy_reg) : GW'(gy_reg);
    mag_next = MAG_W'(gx_abs) + MAG_W'(gy_abs);
    valid3   = tag2_reg & de2_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_out  <= 8'h00;
      edge_out <= 8'h00;
      de_out   <= 1'b0;
      hs_out   <= 1'b0;
      vs_out   <= 1'b0;
    end else begin
      if (!valid3)
        mag_out <= 8'h00;
      else if (mag_next > MAG_W'(255))
        mag_out <= 8'hFF;
      else
        mag_out <= mag_next[7:0];
      edge_out <= (valid3 && (mag_next > thresh)) ? 8'hFF : 8'h00;
      de_out   <= de2_reg;
      hs_out   <= hs2_reg;
      vs_out   <= vs2_reg;
    end
  end

endmodule

// File: tb/tb_sobel_window_core.sv
// Testbench for sobel_window_core: frames are driven from an image array and
// every de_out pulse is compared with a kernel-convolution reference.
module tb_sobel_window_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        de_in, hs_in, vs_in;
  logic [7:0]  pix_in, tap1, tap2;
  logic [10:0] thresh;
  logic        de_out, hs_out, vs_out;
  logic [7:0]  mag_out, edge_out;

  always #5 clk = ~clk;

  sobel_window_core #(.DATA_W(8), .CNT_W(12), .MAG_W(11)) dut (
    .clk(clk), .rst_n(rst_n), .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
    .pix_in(pix_in), .tap1(tap1), .tap2(tap2), .thresh(thresh),
    .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out),
    .mag_out(mag_out), .edge_out(edge_out)
  );

  int checks = 0;
  int errors = 0;
  int img [16][16];
  int got_mag[$];
  int got_edge[$];

  // Collect every output pixel in raster order.
  always @(negedge clk) begin
    if (de_out === 1'b1) begin
      got_mag.push_back(int'(mag_out));
      got_edge.push_back(int'(edge_out));
    end
  end

  // ------------------------------------------------------ reference model
  // Output (r,c) is the Sobel magnitude around image centre (r-1,c-1).
  function automatic int ref_mag(int r, int c);
    int gx, gy, v;
    gx = 0; gy = 0;
    if (r < 2 || c < 2) return 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        v  = img[r - 1 + dr][c - 1 + dc];
        gx += v * dc * ((dr == 0) ? 2 : 1);
        gy += v * dr * ((dc == 0) ? 2 : 1);
      end
    return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
  endfunction

  function automatic int ref_out(int r, int c);
    int m;
    m = ref_mag(r, c);
    return (m > 255) ? 255 : m;
  endfunction

  function automatic int ref_edge(int r, int c, int th);
    if (r < 2 || c < 2) return 0;
    return (ref_mag(r, c) > th) ? 255 : 0;
  endfunction

  // ------------------------------------------------------------- drivers
  task automatic step(input logic de, input logic hs, input logic vs,
                      input int p, input int t1, input int t2);
    @(negedge clk);
    de_in  = de;
    hs_in  = hs;
    vs_in  = vs;
    pix_in = p[7:0];
    tap1   = t1[7:0];
    tap2   = t2[7:0];
  endtask

  task automatic drive_rows(input int w, input int r0, input int r1, input bit vs_with_de);
    for (int r = r0; r < r1; r++) begin
      for (int c = 0; c < w; c++)
        step(1'b1, 1'b0, (vs_with_de && r == 0 && c < 2),
             img[r][c], (r >= 1) ? img[r-1][c] : 0, (r >= 2) ? img[r-2][c] : 0);
      step(1'b0, 1'b1, 1'b0, 0, 0, 0);
      step(1'b0, 1'b1, 1'b0, 0, 0, 0);
      step(1'b0, 1'b0, 1'b0, 0, 0, 0);
      step(1'b0, 1'b0, 1'b0, 0, 0, 0);
    end
  endtask

  task automatic drive_frame(input int w, input int h, input int th, input bit vs_with_de);
    thresh = th[10:0];
    got_mag.delete();
    got_edge.delete();
    step(1'b0, 1'b0, 1'b0, 0, 0, 0);
    if (!vs_with_de) begin
      step(1'b0, 1'b0, 1'b1, 0, 0, 0);
      step(1'b0, 1'b0, 1'b1, 0, 0, 0);
      step(1'b0, 1'b0, 1'b0, 0, 0, 0);
    end
    drive_rows(w, 0, h, vs_with_de);
    repeat (6) step(1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  // --------------------------------------------------------------- tests
  task automatic test_reset();
    logic hist_de[32], hist_hs[32], hist_vs[32];
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      #1;
      checks++;
      if ({de_out, hs_out, vs_out, mag_out, edge_out} !== 19'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got de=%b hs=%b vs=%b mag=%0d edge=%0d, want all 0",
                 i, de_out, hs_out, vs_out, mag_out, edge_out);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        checks++;
        if ({de_out, hs_out, vs_out} !== {hist_de[i-3], hist_hs[i-3], hist_vs[i-3]}) begin
          errors++;
          $display("FAIL sync_delay cycle %0d: got de/hs/vs=%b%b%b, want %b%b%b", i,
                   de_out, hs_out, vs_out, hist_de[i-3], hist_hs[i-3], hist_vs[i-3]);
        end
      end
      hist_de[i] = 1'($urandom);
      hist_hs[i] = 1'($urandom);
      hist_vs[i] = 1'($urandom);
      de_in = hist_de[i];
      hs_in = hist_hs[i];
      vs_in = hist_vs[i];
      pix_in = 8'($urandom);
      tap1 = 8'($urandom);
      tap2 = 8'($urandom);
    end
    repeat (4) step(1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_flat();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = 100;
    drive_frame(8, 8, 10, 1'b0);
    checks++;
    if (got_mag.size() != 64) begin
      errors++;
      $display("FAIL flat_count: got %0d de_out pulses, want 64", got_mag.size());
    end
    for (int i = 0; i < got_mag.size() && i < 64; i++) begin
      checks++;
      if (got_mag[i] != 0 || got_edge[i] != 0) begin
        errors++;
        $display("FAIL flat_pixel %0d: got mag=%0d edge=%0d, want 0/0", i, got_mag[i], got_edge[i]);
      end
    end
  endtask

  task automatic test_vstep();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = (c < 4) ? 0 : 200;
    drive_frame(8, 8, 100, 1'b0);
    checks++;
    if (got_mag.size() != 64) begin
      errors++;
      $display("FAIL vstep_count: got %0d, want 64", got_mag.size());
    end
    for (int i = 0; i < got_mag.size() && i < 64; i++) begin
      checks++;
      if (got_mag[i] != ref_out(i / 8, i % 8) || got_edge[i] != ref_edge(i / 8, i % 8, 100)) begin
        errors++;
        $display("FAIL vstep_pixel (%0d,%0d): got mag=%0d edge=%0d, want %0d/%0d", i / 8, i % 8,
                 got_mag[i], got_edge[i], ref_out(i / 8, i % 8), ref_edge(i / 8, i % 8, 100));
      end
    end
    if (got_mag.size() == 64) begin
      checks++;
      if (got_mag[4*8+4] != 255 || got_edge[4*8+5] != 255 || got_mag[1*8+4] != 0) begin
        errors++;
        $display("FAIL vstep_spot: got (4,4)=%0d edge(4,5)=%0d (1,4)=%0d, want 255/255/0",
                 got_mag[4*8+4], got_edge[4*8+5], got_mag[1*8+4]);
      end
    end
  endtask

  task automatic test_hot_pixel();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = 0;
    img[4][4] = 255;
    drive_frame(8, 8, 0, 1'b0);
    checks++;
    if (got_mag.size() != 64) begin
      errors++;
      $display("FAIL hot_count: got %0d, want 64", got_mag.size());
    end
    for (int i = 0; i < got_mag.size() && i < 64; i++) begin
      checks++;
      if (got_mag[i] != ref_out(i / 8, i % 8) || got_edge[i] != ref_edge(i / 8, i % 8, 0)) begin
        errors++;
        $display("FAIL hot_pixel (%0d,%0d): got mag=%0d edge=%0d, want %0d/%0d", i / 8, i % 8,
                 got_mag[i], got_edge[i], ref_out(i / 8, i % 8), ref_edge(i / 8, i % 8, 0));
      end
    end
    if (got_mag.size() == 64) begin
      checks++;
      if (got_mag[4*8+4] != 255 || got_mag[5*8+5] != 0 || got_edge[6*8+6] != 255) begin
        errors++;
        $display("FAIL hot_spot: got (4,4)=%0d (5,5)=%0d edge(6,6)=%0d, want 255/0/255",
                 got_mag[4*8+4], got_mag[5*8+5], got_edge[6*8+6]);
      end
    end
  endtask

  task automatic test_threshold();
    int th;
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = (r < 4) ? 0 : 10;
    for (int pass = 0; pass < 2; pass++) begin
      th = (pass == 0) ? 40 : 39;
      drive_frame(8, 8, th, 1'b0);
      checks++;
      if (got_mag.size() != 64) begin
        errors++;
        $display("FAIL thresh_count th=%0d: got %0d, want 64", th, got_mag.size());
      end else begin
        checks++;
        if (got_mag[4*8+4] != 40 || got_edge[4*8+4] != ((th == 40) ? 0 : 255)) begin
          errors++;
          $display("FAIL thresh_edge th=%0d: got mag=%0d edge=%0d, want 40/%0d", th,
                   got_mag[4*8+4], got_edge[4*8+4], (th == 40) ? 0 : 255);
        end
      end
      for (int i = 0; i < got_mag.size() && i < 64; i++) begin
        checks++;
        if (got_mag[i] != ref_out(i / 8, i % 8) || got_edge[i] != ref_edge(i / 8, i % 8, th)) begin
          errors++;
          $display("FAIL thresh_pixel th=%0d (%0d,%0d): got %0d/%0d, want %0d/%0d", th, i / 8, i % 8,
                   got_mag[i], got_edge[i], ref_out(i / 8, i % 8), ref_edge(i / 8, i % 8, th));
        end
      end
    end
  endtask

  task automatic test_random();
    int w, h, th;
    for (int f = 0; f < 3; f++) begin
      w  = int'($urandom_range(6, 12));
      h  = int'($urandom_range(5, 10));
      th = int'($urandom_range(0, 600));
      for (int r = 0; r < h; r++) for (int c = 0; c < w; c++) img[r][c] = int'($urandom_range(0, 255));
      drive_frame(w, h, th, (f == 1));
      checks++;
      if (got_mag.size() != w * h) begin
        errors++;
        $display("FAIL rand_count frame %0d: got %0d, want %0d", f, got_mag.size(), w * h);
      end
      for (int i = 0; i < got_mag.size() && i < w * h; i++) begin
        checks++;
        if (got_mag[i] != ref_out(i / w, i % w) || got_edge[i] != ref_edge(i / w, i % w, th)) begin
          errors++;
          $display("FAIL rand_pixel frame %0d (%0d,%0d): got %0d/%0d, want %0d/%0d", f, i / w, i % w,
                   got_mag[i], got_edge[i], ref_out(i / w, i % w), ref_edge(i / w, i % w, th));
        end
      end
    end
  endtask

  task automatic test_midframe_reset();
    int w, h, th;
    w = 10; h = 8; th = 150;
    for (int r = 0; r < h; r++) for (int c = 0; c < w; c++) img[r][c] = int'($urandom_range(0, 255));
    thresh = th[10:0];
    step(1'b0, 1'b0, 1'b1, 0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 0, 0);
    drive_rows(w, 0, 3, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got_mag.delete();
    got_edge.delete();
    drive_rows(w, 3, h, 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b0, 0, 0, 0);
    checks++;
    if (got_mag.size() != (h - 3) * w) begin
      errors++;
      $display("FAIL partial_count: got %0d, want %0d", got_mag.size(), (h - 3) * w);
    end
    for (int i = 0; i < got_mag.size(); i++) begin
      checks++;
      if (got_mag[i] != 0 || got_edge[i] != 0) begin
        errors++;
        $display("FAIL partial_blank %0d: got %0d/%0d, want 0/0", i, got_mag[i], got_edge[i]);
      end
    end
    drive_frame(w, h, th, 1'b0);
    checks++;
    if (got_mag.size() != w * h) begin
      errors++;
      $display("FAIL resync_count: got %0d, want %0d", got_mag.size(), w * h);
    end
    for (int i = 0; i < got_mag.size() && i < w * h; i++) begin
      checks++;
      if (got_mag[i] != ref_out(i / w, i % w) || got_edge[i] != ref_edge(i / w, i % w, th)) begin
        errors++;
        $display("FAIL resync_pixel (%0d,%0d): got %0d/%0d, want %0d/%0d", i / w, i % w,
                 got_mag[i], got_edge[i], ref_out(i / w, i % w), ref_edge(i / w, i % w, th));
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    de_in  = 1'b0;
    hs_in  = 1'b0;
    vs_in  = 1'b0;
    pix_in = 8'd0;
    tap1   = 8'd0;
    tap2   = 8'd0;
    thresh = 11'd0;
    test_reset();
    test_flat();
    test_vstep();
    test_hot_pixel();
    test_threshold();
    test_random();
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
